// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// service FSM states and the hard ceiling on request sources.
package irq_ctrl_pkg;

    localparam int unsigned MAX_SRC = 8;

    localparam logic [1:0] OFS_MASK   = 2'd0;
    localparam logic [1:0] OFS_PEND   = 2'd1;
    localparam logic [1:0] OFS_ACTIVE = 2'd2;
    localparam logic [1:0] OFS_SWTRIG = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAISE    = 2'd1,
        WAIT_EOI = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_select.sv
// Combinational winner search over the eligible vector. The search starts
// at i_start and wraps modulo NUM_SRC; a start of 0 gives fixed priority
// (lowest index wins), any other start gives the round-robin order.
module irq_priority_select #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] i_eligible,
    input  logic [2:0]         i_start,
    output logic               o_found,
    output logic [2:0]         o_id
);

    logic [NUM_SRC-1:0] w_rot;
    logic [3:0]         w_sum;

    // Rotate so that the start index lands on bit 0, take the lowest set
    // bit, then map the rotated position back to a source ID.
    always_comb begin
        w_rot   = NUM_SRC'({i_eligible, i_eligible} >> i_start);
        o_found = 1'b0;
        o_id    = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!o_found && w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_start} + 4'(k);
                if (w_sum >= 4'(NUM_SRC)) begin
                    w_sum = w_sum - 4'(NUM_SRC);
                end
                o_id = w_sum[2:0];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: rising-edge capture of up to eight
// sources into masked pending bits, one-at-a-time presentation to the CPU
// with an ACK / end-of-interrupt handshake, and a 4-register bus window.
// Optional build macro IRQCTL_ROUND_ROBIN_EN selects round-robin priority
// (a last-served register); without it the lowest eligible index wins.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'hE0,
    parameter int unsigned NUM_SRC   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         BUS_ADDR,
    inout  wire  [7:0]         BUS_DATA,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_IRQ,
    output logic [NUM_SRC-1:0] SRC_IRQ_ACK,
    output logic               CPU_IRQ,
    input  logic               CPU_IRQ_ACK
);

    if (NUM_SRC < 1 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
        $error("irq_controller: NUM_SRC out of range");
    end

    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_ack;
    irq_state_t         r_state;
    logic [2:0]         r_id;
    logic               r_valid;
    logic               r_cpu_irq;
    logic               r_rd_en;
    logic [7:0]         r_rd_data;

    logic [7:0]         w_ofs_full;
    logic               w_hit;
    logic [1:0]         w_ofs;
    logic               w_wr;
    logic               w_rd;
    logic               w_eoi;
    logic [NUM_SRC-1:0] w_din;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_consume;
    logic [NUM_SRC-1:0] w_eligible;
    logic [7:0]         w_rd_val;
    logic [2:0]         w_start;
    logic               w_found;
    logic [2:0]         w_win_id;

    // Offset computed by subtraction so any base (aligned or not) decodes
    // exactly four consecutive addresses.
    assign w_ofs_full = BUS_ADDR - BASE_ADDR;
    assign w_hit      = (w_ofs_full[7:2] == 6'd0);
    assign w_ofs      = w_ofs_full[1:0];
    assign w_wr       = BUS_WE & w_hit;
    assign w_rd       = ~BUS_WE & w_hit;
    assign w_eoi      = w_wr && (w_ofs == OFS_ACTIVE);
    assign w_din      = BUS_DATA[NUM_SRC-1:0];

    assign BUS_DATA    = r_rd_en ? r_rd_data : 8'hzz;
    assign SRC_IRQ_ACK = r_ack;
    assign CPU_IRQ     = r_cpu_irq;

    assign w_rise     = SRC_IRQ & ~r_prev;
    assign w_eligible = r_pend & r_mask;

`ifdef IRQCTL_ROUND_ROBIN_EN
    logic [2:0] r_last;

    // Remember the most recently served source to rotate the search start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last <= 3'(NUM_SRC - 1);
        end else if (r_state == IDLE && w_found) begin
            r_last <= w_win_id;
        end
    end

    assign w_start = (r_last == 3'(NUM_SRC - 1)) ? 3'd0 : r_last + 3'd1;
`else
    assign w_start = 3'd0;
`endif

    irq_priority_select #(
        .NUM_SRC(NUM_SRC)
    ) u_sel (
        .i_eligible(w_eligible),
        .i_start   (w_start),
        .o_found   (w_found),
        .o_id      (w_win_id)
    );

    // Set and clear requests for the pending bits; a set overrides a clear.
    always_comb begin
        w_consume = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_consume[i] = (r_state == IDLE) && w_found && (w_win_id == 3'(i));
        end
        w_clr = w_consume;
        if (w_wr && w_ofs == OFS_PEND) begin
            w_clr = w_clr | w_din;
        end
        w_set = w_rise;
        if (w_wr && w_ofs == OFS_SWTRIG) begin
            w_set = w_set | w_din;
        end
    end

    // Register read mux; unused upper bits read as zero.
    always_comb begin
        w_rd_val = '0;
        case (w_ofs)
            OFS_MASK:   w_rd_val = 8'(r_mask);
            OFS_PEND:   w_rd_val = 8'(r_pend);
            OFS_ACTIVE: w_rd_val = {r_valid, 4'b0000, r_id};
            default:    w_rd_val = '0;
        endcase
    end

    // Edge capture, pending bits, mask and the capture acknowledge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prev <= '0;
            r_pend <= '0;
            r_mask <= '0;
            r_ack  <= '0;
        end else begin
            r_prev <= SRC_IRQ;
            r_ack  <= w_rise;
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_wr && w_ofs == OFS_MASK) begin
                r_mask <= w_din;
            end
        end
    end

    // One-cycle registered read response on the shared bus.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_en   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_en   <= w_rd;
            r_rd_data <= w_rd ? w_rd_val : 8'h00;
        end
    end

    // Service FSM: pick a winner, raise CPU_IRQ, wait for ACK, then EOI.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_valid   <= 1'b0;
            r_cpu_irq <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_id      <= w_win_id;
                        r_valid   <= 1'b1;
                        r_cpu_irq <= 1'b1;
                        r_state   <= RAISE;
                    end
                end
                RAISE: begin
                    if (CPU_IRQ_ACK) begin
                        r_cpu_irq <= 1'b0;
                        r_state   <= WAIT_EOI;
                    end
                end
                WAIT_EOI: begin
                    if (w_eoi) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_cpu_irq <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed scenarios followed by
// random traffic, checked against a behavioural model of the controller.
module tb_irq_controller;

    localparam logic [7:0]  BASE = 8'hE0;
    localparam int unsigned N    = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [7:0]   addr;
    logic         we;
    logic [N-1:0] irq;
    logic [N-1:0] ack_o;
    logic         cpu_irq;
    logic         cpu_ack;
    logic         drv;
    logic [7:0]   dout;
    wire  [7:0]   bus;

    assign bus = drv ? dout : 8'hzz;

    always #5 CLK = ~CLK;

    irq_controller #(
        .BASE_ADDR(BASE),
        .NUM_SRC  (N)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BUS_ADDR   (addr),
        .BUS_DATA   (bus),
        .BUS_WE     (we),
        .SRC_IRQ    (irq),
        .SRC_IRQ_ACK(ack_o),
        .CPU_IRQ    (cpu_irq),
        .CPU_IRQ_ACK(cpu_ack)
    );

    typedef struct {
        bit         irq;
        bit [N-1:0] ack;
        bit         rd;
        bit [7:0]   data;
        bit         has_k;
        bit [7:0]   kdata;
    } exp_t;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Behavioural model state
    bit [N-1:0] m_prev, m_pend, m_mask;
    int         m_phase;   // 0 = idle, 1 = interrupt raised, 2 = awaiting EOI
    int         m_id;
    bit         m_valid;
    int         m_last;

    // Inputs applied in the current cycle
    bit [N-1:0] s_irq;
    bit         s_we, s_ack;
    bit [7:0]   s_addr, s_data;
    bit         last_rd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '0;
        m_phase = 0; m_id = 0; m_valid = 1'b0; m_last = N - 1;
    endtask

    function automatic int pick();
        int start;
`ifdef IRQCTL_ROUND_ROBIN_EN
        start = (m_last + 1) % N;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (m_pend[j] && m_mask[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit [7:0] reg_val(input int off);
        case (off)
            0: return 8'(m_mask);
            1: return 8'(m_pend);
            2: return {m_valid, 4'b0000, 3'(m_id)};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input bit hk, input bit [7:0] kd);
        exp_t       e;
        bit [7:0]   d8;
        int         off, w;
        bit         hit;
        bit [N-1:0] rise, setv, clrv;
        d8   = s_addr - BASE;
        hit  = (d8 < 8'd4);
        off  = int'(d8);
        e.rd = hit && !s_we;
        e.data = e.rd ? reg_val(off) : 8'h00;
        clrv = '0;
        if (m_phase == 0) begin
            w = pick();
            if (w >= 0) begin
                m_id = w; m_valid = 1'b1; m_phase = 1; m_last = w;
                clrv[w] = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (s_ack) m_phase = 2;
        end else begin
            if (s_we && hit && off == 2) begin
                m_valid = 1'b0; m_phase = 0;
            end
        end
        rise = s_irq & ~m_prev;
        setv = rise;
        if (s_we && hit && off == 1) clrv = clrv | s_data[N-1:0];
        if (s_we && hit && off == 3) setv = setv | s_data[N-1:0];
        m_pend = (m_pend & ~clrv) | setv;
        if (s_we && hit && off == 0) m_mask = s_data[N-1:0];
        m_prev = s_irq;
        e.irq   = (m_phase == 1);
        e.ack   = rise;
        e.has_k = hk;
        e.kdata = kd;
        q.push_back(e);
    endtask

    task automatic drive(input bit [N-1:0] i, input bit w, input bit [7:0] a, input bit [7:0] d,
                         input bit k, input bit hk, input bit [7:0] kd);
        bit [7:0] d8;
        @(negedge CLK);
        irq = i; we = w; addr = a; dout = d; drv = w; cpu_ack = k;
        s_irq = i; s_we = w; s_addr = a; s_data = d; s_ack = k;
        @(posedge CLK);
        model_step(hk, kd);
        d8 = a - BASE;
        last_rd = !w && (d8 < 8'd4);
    endtask

    // A write right after a read would collide with the read response.
    task automatic cycle(input bit [N-1:0] i, input bit w, input bit [7:0] a, input bit [7:0] d,
                         input bit k, input bit hk, input bit [7:0] kd);
        if (w && last_rd) drive(irq, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        drive(i, w, a, d, k, hk, kd);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(irq, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr(input int off, input bit [7:0] d);
        cycle(irq, 1'b1, BASE + 8'(off), d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rdk(input int off, input bit [7:0] kd);
        cycle(irq, 1'b0, BASE + 8'(off), 8'h00, 1'b0, 1'b1, kd);
    endtask

    task automatic set_irq(input bit [N-1:0] v);
        cycle(v, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic cpu_ack1();
        cycle(irq, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST = 1'b1; drv = 1'b0; we = 1'b0; irq = '0; cpu_ack = 1'b0; addr = 8'h00;
        #1;
        check("rst_cpu_irq", {31'd0, cpu_irq}, 32'd0);
        check("rst_src_ack", 32'(ack_o), 32'd0);
        q.delete();
        model_reset();
        last_rd = 1'b0;
        @(negedge CLK);
        #2;
        RST = 1'b0;
    endtask

    // Monitor: pops one expected record per presented cycle and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && q.size() != 0) begin
                e = q.pop_front();
                check("cpu_irq", {31'd0, cpu_irq}, {31'd0, e.irq});
                check("src_irq_ack", 32'(ack_o), 32'(e.ack));
                if (e.rd) check("read_data", 32'(bus), 32'(e.data));
                if (e.has_k) check("read_const", 32'(bus), 32'(e.kdata));
            end
        end
    end

    initial begin
        bit [N-1:0] ni;
        bit         k;
        int         r;
        bit [7:0]   first_k, second_k;
        irq = '0; we = 1'b0; addr = 8'h00; dout = 8'h00; drv = 1'b0; cpu_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b0;

        // Timer on src0
        wr(0, 8'h01);
        set_irq(4'b0001);
        idle(1);
        rdk(2, 8'h80);
        cpu_ack1();
        wr(2, 8'h00);
        set_irq(4'b0000);
        idle(2);

        // Masked source held pending, then unmasked
        wr(0, 8'h00);
        set_irq(4'b0100);
        idle(1);
        rdk(1, 8'h04);
        idle(2);
        wr(0, 8'h04);
        idle(2);
        rdk(2, 8'h82);
        cpu_ack1();
        wr(2, 8'h00);
        set_irq(4'b0000);
        idle(2);

        // Simultaneous src1 and src3
`ifdef IRQCTL_ROUND_ROBIN_EN
        first_k = 8'h83; second_k = 8'h81;
`else
        first_k = 8'h81; second_k = 8'h83;
`endif
        wr(0, 8'h0F);
        set_irq(4'b1010);
        idle(1);
        rdk(2, first_k);
        cpu_ack1();
        wr(2, 8'h00);
        idle(2);
        rdk(2, second_k);
        cpu_ack1();
        wr(2, 8'h00);
        set_irq(4'b0000);
        idle(2);

        // W1C colliding with a rise: the set wins
        wr(0, 8'h00);
        cycle(4'b0010, 1'b1, BASE + 8'd1, 8'h02, 1'b0, 1'b0, 8'h00);
        rdk(1, 8'h02);
        wr(1, 8'h02);
        rdk(1, 8'h00);
        set_irq(4'b0000);

        // Software trigger, then reset while the interrupt is raised
        wr(0, 8'h08);
        wr(3, 8'h08);
        idle(1);
        rdk(2, 8'h83);
        do_reset();
        rdk(0, 8'h00);
        rdk(1, 8'h00);
        rdk(2, 8'h00);
        rdk(3, 8'h00);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            ni = irq;
            if ($urandom_range(0, 3) == 0) ni = N'($urandom);
            k = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 9);
            if (r < 4)
                cycle(ni, 1'b0, 8'h00, 8'h00, k, 1'b0, 8'h00);
            else if (r < 7)
                cycle(ni, 1'b0, BASE + 8'($urandom_range(0, 4)), 8'h00, k, 1'b0, 8'h00);
            else
                cycle(ni, 1'b1, BASE + 8'($urandom_range(0, 4)), 8'($urandom), k, 1'b0, 8'h00);
        end

        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge CLK);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d records left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
